// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider and its consumers.
package div_pkg;
  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} div_state_e;

  localparam int DIV_WIDTH    = 32;
  localparam int DIV_ITERS    = 32;
  // Edges from start acceptance to the edge that raises done.
  localparam int DIV_LAT      = 34;
  localparam int DIV_ZERO_LAT = 1;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract divisor.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < dvs always, so the shifted value fits WIDTH+1 bits and diff's MSB is the borrow.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_i};

  always_comb begin
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/div_unit.sv
// Iterative signed 32-bit divider with start/done handshake and divide-by-zero pulse.
// Optional macro DIV_UNSIGNED_EN adds is_unsigned for DIVU semantics.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q_q, sgn_q_d, sgn_r_q, sgn_r_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic             signed_mode;
  logic [WIDTH-1:0] step_rem, step_quo;

`ifdef DIV_UNSIGNED_EN
  logic uns_q, uns_d;
  assign signed_mode = !uns_q;
`else
  assign signed_mode = 1'b1;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sgn_q_d = sgn_q_q;
    sgn_r_d = sgn_r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
`ifdef DIV_UNSIGNED_EN
    uns_d   = uns_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
`ifdef DIV_UNSIGNED_EN
          uns_d   = is_unsigned;
`endif
          busy_d  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        if (b_q == '0) begin
          done_d  = 1'b1;
          dz_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          // Magnitudes are unsigned WIDTH-bit, so |most-negative| is exact.
          quo_d   = (signed_mode && a_q[WIDTH-1]) ? -a_q : a_q;
          dvs_d   = (signed_mode && b_q[WIDTH-1]) ? -b_q : b_q;
          sgn_q_d = signed_mode && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sgn_r_d = signed_mode && a_q[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        lo_d    = sgn_q_q ? -quo_q : quo_q;
        hi_d    = sgn_r_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      sgn_q_q <= 1'b0;
      sgn_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef DIV_UNSIGNED_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      sgn_q_q <= sgn_q_d;
      sgn_r_q <= sgn_r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef DIV_UNSIGNED_EN
      uns_q   <= uns_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: cycle-level behavioural model checked every cycle, plus literal expectations.
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        is_unsigned;
  logic        busy, done, div_zero;
  logic [31:0] hi_out, lo_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
`ifdef DIV_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: truncating division, remainder takes dividend's sign.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input bit uns,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sx, sy;
    if (uns) begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
    end else begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end
    q = 32'(sx / sy);
    r = 32'(sx % sy);
  endfunction

  // Transaction-level model: counts edges since acceptance, no internal state encoding.
  logic        m_busy, m_done, m_dz;
  logic [31:0] m_hi, m_lo, m_a, m_b;
  bit          m_uns;
  int          m_elapsed;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0; m_elapsed = 0;
    end else begin
      m_done = 0;
      m_dz   = 0;
      if (m_busy) begin
        m_elapsed++;
        if (m_b == 0 && m_elapsed == DIV_ZERO_LAT) begin
          m_busy = 0; m_done = 1; m_dz = 1;
        end else if (m_elapsed == DIV_LAT) begin
          m_busy = 0; m_done = 1;
          ref_div(m_a, m_b, m_uns, m_lo, m_hi);
        end
      end else if (start) begin
        m_busy = 1; m_elapsed = 0; m_a = a; m_b = b;
`ifdef DIV_UNSIGNED_EN
        m_uns = is_unsigned;
`else
        m_uns = 0;
`endif
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("div_zero", {31'b0, div_zero}, {31'b0, m_dz});
    chk("hi_out", hi_out, m_hi);
    chk("lo_out", lo_out, m_lo);
  end

  task automatic wait_done(input int elat);
    int n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, elat);
  endtask

  // Called at a negedge; scrambles operands after acceptance to catch re-sampling.
  task automatic run(input logic [31:0] ia, input logic [31:0] ib, input bit iu,
                     input logic [31:0] elo, input logic [31:0] ehi, input bit edz);
    a = ia; b = ib; is_unsigned = iu; start = 1;
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom; is_unsigned = ~iu;
    wait_done(edz ? DIV_ZERO_LAT + 1 : DIV_LAT + 1);
    chk("lit_lo", lo_out, elo);
    chk("lit_hi", hi_out, ehi);
    chk("lit_dz", {31'b0, div_zero}, {31'b0, edz});
  endtask

  initial begin
    reset = 1; start = 0; a = 0; b = 0; is_unsigned = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    reset = 0;
    @(negedge clk);

    run(32'd7, 32'd2, 0, 32'h3, 32'h1, 0);
    // start coincident with the done cycle of the previous op
    run(32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    run(32'd7, 32'hFFFFFFFE, 0, 32'hFFFFFFFD, 32'h1, 0);
    run(32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 32'h0, 0);
    run(32'hFFFFFF9C, 32'hFFFFFFF9, 0, 32'd14, 32'hFFFFFFFE, 0);
    run(32'd0, 32'd5, 0, 32'd0, 32'd0, 0);
    run(32'd3, 32'd10, 0, 32'd0, 32'd3, 0);
    run(32'h7FFFFFFF, 32'd1, 0, 32'h7FFFFFFF, 32'd0, 0);
    run(32'd7, 32'd2, 0, 32'h3, 32'h1, 0);
    run(32'd5, 32'd0, 0, 32'h3, 32'h1, 1);
    @(negedge clk);

    // start re-pulsed mid-operation with other operands is ignored
    a = 32'd100; b = 32'd3; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    a = 32'd9; b = 32'd4; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(DIV_LAT + 1 - 5);
    chk("repulse_lo", lo_out, 32'd33);
    chk("repulse_hi", hi_out, 32'd1);
    @(negedge clk);

    // asynchronous reset mid-division
    a = 32'd100; b = 32'd3; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_hi", hi_out, 32'd0);
    chk("arst_lo", lo_out, 32'd0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    run(32'd9, 32'd4, 0, 32'd2, 32'd1, 0);

`ifdef DIV_UNSIGNED_EN
    run(32'hFFFFFFFF, 32'd2, 1, 32'h7FFFFFFF, 32'd1, 0);
    run(32'h80000000, 32'hFFFFFFFF, 1, 32'd0, 32'h80000000, 0);
    run(32'd9, 32'd0, 1, 32'd0, 32'h80000000, 1);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative signed 32-bit divider for the multicycle CPU's DIV path.
- Sits beside the multiplier, downstream of the A/B operand registers; its results feed the HI and LO register inputs.
- Uses a start/done handshake with the control unit, mirroring the multiplier's control/end pair.
- Raises a divide-by-zero flag that the control unit uses to select the exception vector address.

Parameters:
- WIDTH, 32, operand/result width in bits (the core only ever uses 32).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse from the control unit (DivOp); sampled only in IDLE.
- a  in  WIDTH  dividend (A register output).
- b  in  WIDTH  divisor (B register output).
- busy  out  1  high from the edge that accepts start until the edge that raises done.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse coincident with done when b==0.
- hi_out  out  WIDTH  remainder; goes to the HI register input.
- lo_out  out  WIDTH  quotient; goes to the LO register input.

Behaviour:
- Reset, asynchronous, at any time including mid-division:
  - State goes to IDLE; busy, done and div_zero go to 0; hi_out and lo_out go to 0.
  - Counter and internal operands are cleared.
- States and transitions (E = the edge on which start is sampled high in IDLE):
  - IDLE: on start, latch a and b, busy<=1, go to PREP (at E).
  - PREP: if latched b==0, then done<=1, div_zero<=1, busy<=0, hi/lo unchanged, go to IDLE (at E+1). Otherwise load |a| and |b|, record sign_q = a[31]^b[31] and sign_r = a[31], clear the remainder accumulator, counter<=0, go to ITER (at E+1).
  - ITER: one restoring step per edge, MSB first:
    - Shift {rem, quo} left by 1.
    - Trial-subtract |b| from rem; if non-negative, keep the difference and set quo[0]=1.
    - 32 steps on edges E+2..E+33; after the 32nd step go to FIX.
  - FIX (edge E+34): lo_out <= sign_q ? -quo : quo; hi_out <= sign_r ? -rem : rem; done<=1; busy<=0; go to IDLE.
- Latency:
  - Normal divide: done is high in the cycle following edge E+34.
  - b==0: done is high in the cycle following edge E+1.
- done and div_zero are high for exactly one cycle; they clear on the next edge unconditionally.
- hi_out and lo_out hold their value until the next successful FIX; they are never updated on div_zero.
- Arithmetic:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Magnitudes are held in WIDTH bits, unsigned, so |0x80000000| is representable.
  - Overflow case 0x80000000 / 0xFFFFFFFF wraps: lo=0x80000000, hi=0; no flag is raised.
- start while busy is ignored; a and b are not re-sampled during an operation.
- start coincident with done: the new start is accepted only on a later edge (state must be IDLE when sampled).

Optional Feature:
- Macro: DIV_UNSIGNED_EN.
- Defined:
  - Adds input port is_unsigned (1 bit), latched with start.
  - When latched high, PREP skips absolute values and FIX skips negation, giving DIVU semantics.
  - Latency and zero handling are identical to signed mode.
- Undefined: the port is absent and the unit is signed only.

Decomposition:
- Shared package div_pkg:
  - State enum {IDLE, PREP, ITER, FIX}.
  - DIV_WIDTH=32 and DIV_ITERS=32.
  - Latency constants DIV_LAT=34 and DIV_ZERO_LAT=1, for the control unit and bench.
- One natural sub-module, div_step: combinational single restoring step.
  - Inputs: rem, quo, divisor magnitude.
  - Outputs: next rem and next quo.
  - Instantiated once and iterated by the counter.

Test Plan:
- a=7, b=2, start pulse -> done at E+34: lo=0x00000003, hi=0x00000001, div_zero=0; busy high for cycles E..E+34.
- a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_zero=0.
- Preload hi/lo via 7/2, then a=5, b=0 -> done and div_zero both pulse at E+1; hi=1 and lo=3 retained.
- a=100, b=3; reset asserted asynchronously at E+10 -> busy, done, hi, lo all 0 immediately; the next start of 9/4 gives lo=2, hi=1 at E'+34.
- start re-pulsed at E+5 with different operands -> ignored; result still that of the first operation.
- With DIV_UNSIGNED_EN: a=0xFFFFFFFF, b=2, is_unsigned=1 -> lo=0x7FFFFFFF, hi=1.
